tx_frame_packer: RTL

- Byte-stream framer in the aclk domain, directly upstream of the transmit async FIFO.
- Wraps each payload of bytes into 32-bit FIFO words: preamble, header, packed payload, trailer.
- Drives the FIFO write port (wr_data/fifo_wr_en) and obeys fifo_full backpressure, so the pclk-side shifter and VPPM stages receive complete, self-delimiting frames.

---
 rtl/tx_frame_packer.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/tx_frame_packer.sv
// Byte-stream framer feeding the transmit async FIFO: preamble, header, packed payload, trailer.
// Optional CRC-16/CCITT-FALSE trailer word when TX_CRC_EN is defined.
module tx_frame_packer #(
    parameter logic [31:0] PREAMBLE  = 32'hAA55AA55,
    parameter logic [7:0]  SYNC      = 8'hD5,
    parameter int unsigned MAX_BYTES = 1024
) (
    input  logic        aclk,
    input  logic        reset,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [31:0] wr_data,
    output logic        fifo_wr_en,
    input  logic        fifo_full,
    output logic        busy,
    output logic        frame_done,
    output logic        err_overlen,
    output logic [7:0]  seq
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned WORD_W = 32;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);
    localparam logic [7:0] TRL_TAG = 8'hC3;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PRE  = 3'd1;
    localparam logic [2:0] ST_HDR  = 3'd2;
    localparam logic [2:0] ST_PAY  = 3'd3;
    localparam logic [2:0] ST_TRL  = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;
`ifdef TX_CRC_EN
    localparam logic [2:0] ST_CRC  = 3'd6;
`endif

    logic [2:0]        state_q, state_d;
    logic [7:0]        seq_q, seq_d;
    logic [WORD_W-1:0] pack_q, pack_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              pending_q, pending_d;
    logic              final_q, final_d;
    logic [CNT_W-1:0]  count_inc;
    logic              want_wr;
`ifdef TX_CRC_EN
    logic [15:0]       crc_q, crc_d;

    // One byte of CRC-16/CCITT-FALSE, MSB first.
    function automatic logic [15:0] crc_step(input logic [15:0] crc_in, input logic [7:0] b);
        logic [15:0] c;
        c = crc_in ^ {b, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction
`endif

    assign count_inc = count_q + 16'd1;
    assign seq       = seq_q;

    // Next-state, packer and FIFO write port; a write completes only when fifo_full is low.
    always_comb begin
        state_d     = state_q;
        seq_d       = seq_q;
        pack_d      = pack_q;
        count_d     = count_q;
        pending_d   = pending_q;
        final_d     = final_q;
`ifdef TX_CRC_EN
        crc_d       = crc_q;
`endif
        want_wr     = 1'b0;
        s_ready     = 1'b0;
        wr_data     = '0;
        busy        = (state_q != ST_IDLE);
        frame_done  = 1'b0;
        err_overlen = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (s_valid) begin
                    state_d = ST_PRE;
                end
            end
            ST_PRE: begin
                want_wr = 1'b1;
                wr_data = PREAMBLE;
                if (!fifo_full) begin
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                want_wr   = 1'b1;
                wr_data   = {SYNC, seq_q, 16'h0000};
                pack_d    = '0;
                count_d   = '0;
                pending_d = 1'b0;
                final_d   = 1'b0;
`ifdef TX_CRC_EN
                crc_d     = 16'hFFFF;
`endif
                if (!fifo_full) begin
                    state_d = ST_PAY;
                end
            end
            ST_PAY: begin
                s_ready = !pending_q;
                if (pending_q) begin
                    want_wr = 1'b1;
                    wr_data = pack_q;
                    if (!fifo_full) begin
                        pending_d = 1'b0;
                        pack_d    = '0;
                        if (final_q) begin
                            state_d = ST_TRL;
                        end
                    end
                end else if (s_valid) begin
                    count_d = count_inc;
                    // Lane comes from the running count; each word starts at lane 0.
                    case (count_q[1:0])
                        2'd0:    pack_d[31:24] = s_data;
                        2'd1:    pack_d[23:16] = s_data;
                        2'd2:    pack_d[15:8]  = s_data;
                        default: pack_d[7:0]   = s_data;
                    endcase
`ifdef TX_CRC_EN
                    crc_d = crc_step(crc_q, s_data);
`endif
                    if (s_last || (count_inc == MAX_CNT)) begin
                        pending_d   = 1'b1;
                        final_d     = 1'b1;
                        err_overlen = !s_last;
                    end else if (count_q[1:0] == 2'd3) begin
                        pending_d = 1'b1;
                    end
                end
            end
            ST_TRL: begin
                want_wr = 1'b1;
                wr_data = {TRL_TAG, 8'h00, count_q};
                if (!fifo_full) begin
`ifdef TX_CRC_EN
                    state_d = ST_CRC;
`else
                    state_d = ST_DONE;
`endif
                end
            end
`ifdef TX_CRC_EN
            ST_CRC: begin
                want_wr = 1'b1;
                wr_data = {16'h0000, crc_q};
                if (!fifo_full) begin
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                frame_done = 1'b1;
                seq_d      = seq_q + 8'd1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        fifo_wr_en = want_wr && !fifo_full;
    end

    // State registers; reset drops any partial frame.
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            seq_q     <= '0;
            pack_q    <= '0;
            count_q   <= '0;
            pending_q <= 1'b0;
            final_q   <= 1'b0;
`ifdef TX_CRC_EN
            crc_q     <= 16'hFFFF;
`endif
        end else begin
            state_q   <= state_d;
            seq_q     <= seq_d;
            pack_q    <= pack_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            final_q   <= final_d;
`ifdef TX_CRC_EN
            crc_q     <= crc_d;
`endif
        end
    end

endmodule
